// File: rtl/outbuff_cntl.sv
// Output-buffer controller: skids engine results through a 2-entry buffer into the
// output SRAM FIFO, tracking parity-row / stripe position and overflow.
module outbuff_cntl #(
  parameter  int M_MAX         = 128,
  parameter  int M_MIN         = 2,
  parameter  int W             = 4,
  parameter  int PACKET_LENGTH = 2,
  parameter  int STRIPE_CNT_W  = 16,
  localparam int OUT_DATA_W    = W * PACKET_LENGTH,
  localparam int MREG_W        = $clog2(M_MAX)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    eng_rstn,
  input  logic                    cntrl_outbuff_wr_en,
  input  logic [MREG_W-1:0]       MReg,
  input  logic [OUT_DATA_W-1:0]   eng_res_data,
  input  logic                    eng_res_val,
  output logic                    eng_res_rdy,
  output logic                    cntl_outbuf_fifo_wr_rq,
  output logic                    cntl_outbuf_fifo_mem_en,
  output logic [OUT_DATA_W-1:0]   cntl_outbuf_fifo_wr_data,
  input  logic                    outbuf_fifo_cntl_full,
  output logic [MREG_W-1:0]       row_idx,
  output logic                    stripe_done,
  output logic [STRIPE_CNT_W-1:0] stripe_cnt,
  output logic                    outbuf_cntl_idle,
  output logic                    ovf_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [OUT_DATA_W-1:0]   r_buf [2];
  logic                    r_wr_ptr;
  logic                    r_rd_ptr;
  logic [1:0]              r_count;
  logic [MREG_W:0]         r_rows;
  logic [MREG_W-1:0]       r_row_idx;
  logic                    r_last_wr;
  logic                    r_stripe_done;
  logic [STRIPE_CNT_W-1:0] r_stripe_cnt;
  logic                    r_wr_rq;
  logic [OUT_DATA_W-1:0]   r_wr_data;
  logic                    r_idle;
  logic                    r_ovf;

  logic                    w_accept;
  logic                    w_write;
  logic [1:0]              w_count_next;
  logic [MREG_W:0]         w_mreg_rows;
  logic [MREG_W:0]         w_rows;
  logic                    w_last;

  // Ready depends only on the registered fill level, never on val.
  assign eng_res_rdy = (r_count != 2'd2);
  assign w_accept    = eng_res_val && eng_res_rdy;
  assign w_write     = (r_count != 2'd0) && !outbuf_fifo_cntl_full &&
                       ((r_state == S_ACTIVE) || (r_state == S_FLUSH));

  always_comb begin
    w_count_next = r_count;
    case ({w_accept, w_write})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Stripe length is only re-sampled at a stripe boundary.
  always_comb begin
    w_mreg_rows = {1'b0, MReg} + (MREG_W+1)'(1);
    if (w_mreg_rows < (MREG_W+1)'(M_MIN))
      w_mreg_rows = (MREG_W+1)'(M_MIN);
    w_rows = (r_row_idx == '0) ? w_mreg_rows : r_rows;
    w_last = ({1'b0, r_row_idx} == (w_rows - (MREG_W+1)'(1)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_rows        <= (MREG_W+1)'(M_MIN);
      r_row_idx     <= '0;
      r_last_wr     <= 1'b0;
      r_stripe_done <= 1'b0;
      r_stripe_cnt  <= '0;
      r_wr_rq       <= 1'b0;
      r_wr_data     <= '0;
      r_idle        <= 1'b1;
      r_ovf         <= 1'b0;
    end else if (!eng_rstn) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
      r_wr_ptr      <= 1'b0;
      r_rd_ptr      <= 1'b0;
      r_count       <= 2'd0;
      r_rows        <= (MREG_W+1)'(M_MIN);
      r_row_idx     <= '0;
      r_last_wr     <= 1'b0;
      r_stripe_done <= 1'b0;
      r_stripe_cnt  <= '0;
      r_wr_rq       <= 1'b0;
      r_wr_data     <= '0;
      r_idle        <= 1'b1;
      r_ovf         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf[r_wr_ptr] <= eng_res_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end

      r_rows <= w_rows;
      if (w_write) begin
        r_wr_data <= r_buf[r_rd_ptr];
        r_rd_ptr  <= ~r_rd_ptr;
        r_row_idx <= w_last ? '0 : r_row_idx + MREG_W'(1);
      end
      r_count <= w_count_next;
      r_wr_rq <= w_write;

      r_last_wr     <= w_write && w_last;
      r_stripe_done <= r_last_wr;
      if (r_last_wr)
        r_stripe_cnt <= r_stripe_cnt + STRIPE_CNT_W'(1);

      if (eng_res_val && !eng_res_rdy)
        r_ovf <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (cntrl_outbuff_wr_en) begin
            r_state <= S_ACTIVE;
            r_idle  <= 1'b0;
          end else begin
            r_idle  <= (w_count_next == 2'd0);
          end
        end
        S_ACTIVE: begin
          if (!cntrl_outbuff_wr_en) begin
            if (w_count_next != 2'd0) begin
              r_state <= S_FLUSH;
              r_idle  <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_idle  <= 1'b1;
            end
          end else begin
            r_idle <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (cntrl_outbuff_wr_en) begin
            r_state <= S_ACTIVE;
            r_idle  <= 1'b0;
          end else if (w_count_next == 2'd0) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
          end else begin
            r_idle  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= (w_count_next == 2'd0);
        end
      endcase
    end
  end

  assign cntl_outbuf_fifo_wr_rq   = r_wr_rq;
  assign cntl_outbuf_fifo_mem_en  = r_wr_rq;
  assign cntl_outbuf_fifo_wr_data = r_wr_data;
  assign row_idx                  = r_row_idx;
  assign stripe_done              = r_stripe_done;
  assign stripe_cnt               = r_stripe_cnt;
  assign outbuf_cntl_idle         = r_idle;
  assign ovf_err                  = r_ovf;

endmodule

// File: tb/tb_outbuff_cntl.sv
// Directed self-checking bench for outbuff_cntl.
module tb_outbuff_cntl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        eng_rstn;
  logic        wr_en;
  logic [6:0]  mreg;
  logic [7:0]  res_data;
  logic        res_val;
  logic        res_rdy;
  logic        wr_rq;
  logic        mem_en;
  logic [7:0]  wr_data;
  logic        full;
  logic [6:0]  row_idx;
  logic        stripe_done;
  logic [15:0] stripe_cnt;
  logic        idle;
  logic        ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  outbuff_cntl dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .eng_rstn                 (eng_rstn),
    .cntrl_outbuff_wr_en      (wr_en),
    .MReg                     (mreg),
    .eng_res_data             (res_data),
    .eng_res_val              (res_val),
    .eng_res_rdy              (res_rdy),
    .cntl_outbuf_fifo_wr_rq   (wr_rq),
    .cntl_outbuf_fifo_mem_en  (mem_en),
    .cntl_outbuf_fifo_wr_data (wr_data),
    .outbuf_fifo_cntl_full    (full),
    .row_idx                  (row_idx),
    .stripe_done              (stripe_done),
    .stripe_cnt               (stripe_cnt),
    .outbuf_cntl_idle         (idle),
    .ovf_err                  (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Back-to-back stream of n words into an empty, ACTIVE block starting at row 0.
  task automatic stream(input int n, input int base, input int rows, input int cnt0);
    int m;
    int s;
    for (int k = 1; k <= n + 2; k++) begin
      res_val  = (k <= n);
      res_data = 8'(base + k - 1);
      tick();
      m = (k - 1 < n) ? k - 1 : n;
      s = (k >= 2) ? (((k - 2 < n) ? k - 2 : n) / rows) : 0;
      $display("stream k=%0d wr_rq=%0b data=0x%0h row=%0d done=%0b cnt=%0d",
               k, wr_rq, wr_data, row_idx, stripe_done, stripe_cnt);
      chk("str_wr_rq", 32'(wr_rq), 32'(k >= 2 && k <= n + 1));
      chk("str_mem_en", 32'(mem_en), 32'(k >= 2 && k <= n + 1));
      if (k >= 2 && k <= n + 1) chk("str_data", 32'(wr_data), 32'(base + k - 2));
      chk("str_row", 32'(row_idx), 32'(m % rows));
      chk("str_done", 32'(stripe_done), 32'(k >= 3 && (k - 2) <= n && ((k - 2) % rows) == 0));
      chk("str_cnt", 32'(stripe_cnt), 32'(cnt0 + s));
      chk("str_rdy", 32'(res_rdy), 32'd1);
    end
    res_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expq[$];
    int mcnt, sent, got_n, cyc;
    logic acc, mwr, full_prev;

    rstn = 1'b0; eng_rstn = 1'b1; wr_en = 1'b0; mreg = 7'd0;
    res_data = 8'h00; res_val = 1'b0; full = 1'b0;
    tick(); tick();
    $display("reset rdy=%0b wr_rq=%0b idle=%0b ovf=%0b", res_rdy, wr_rq, idle, ovf);
    chk("rst_rdy", 32'(res_rdy), 32'd1);
    chk("rst_wr_rq", 32'(wr_rq), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_row", 32'(row_idx), 32'd0);
    chk("rst_done", 32'(stripe_done), 32'd0);
    chk("rst_cnt", 32'(stripe_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Basic stream, 4 rows per stripe.
    rstn = 1'b1; mreg = 7'd3; wr_en = 1'b1;
    tick();
    chk("act_idle", 32'(idle), 32'd0);
    stream(8, 8'h01, 4, 0);

    // FIFO full for 5 edges while streaming six words.
    mcnt = 0; sent = 0; got_n = 0; cyc = 0; full_prev = 1'b0;
    while ((sent < 6 || mcnt > 0) && cyc < 40) begin
      full = (cyc < 5);
      acc  = (mcnt < 2) && (sent < 6);
      mwr  = (mcnt > 0) && !full;
      res_val  = acc;
      res_data = 8'(8'h11 + sent);
      if (acc) begin
        expq.push_back(8'(8'h11 + sent));
        sent++;
      end
      mcnt = mcnt + int'(acc) - int'(mwr);
      full_prev = full;
      tick();
      $display("full cyc=%0d full=%0b rdy=%0b wr_rq=%0b data=0x%0h", cyc, full_prev, res_rdy, wr_rq, wr_data);
      chk("full_rdy", 32'(res_rdy), 32'(mcnt < 2));
      chk("full_wr_rq", 32'(wr_rq), 32'(mwr));
      if (mwr) begin
        chk("full_data", 32'(wr_data), 32'(expq.pop_front()));
        got_n++;
      end
      cyc++;
    end
    res_val = 1'b0; full = 1'b0;
    chk("full_all_written", 32'(got_n), 32'd6);
    chk("full_row", 32'(row_idx), 32'd2);
    tick();
    chk("full_cnt", 32'(stripe_cnt), 32'd3);
    chk("full_ovf", 32'(ovf), 32'd0);

    // Soft reset mid-stripe with one word buffered.
    full = 1'b1; res_val = 1'b1; res_data = 8'h55;
    tick();
    res_val = 1'b0;
    chk("srst_pre_row", 32'(row_idx), 32'd2);
    chk("srst_pre_wr", 32'(wr_rq), 32'd0);
    full = 1'b0; eng_rstn = 1'b0;
    tick();
    $display("soft reset row=%0d rdy=%0b wr_rq=%0b cnt=%0d", row_idx, res_rdy, wr_rq, stripe_cnt);
    chk("srst_row", 32'(row_idx), 32'd0);
    chk("srst_rdy", 32'(res_rdy), 32'd1);
    chk("srst_wr", 32'(wr_rq), 32'd0);
    chk("srst_cnt", 32'(stripe_cnt), 32'd0);
    chk("srst_idle", 32'(idle), 32'd1);
    eng_rstn = 1'b1;
    tick();
    chk("srst_wr1", 32'(wr_rq), 32'd0);
    tick();
    chk("srst_wr2", 32'(wr_rq), 32'd0);

    // MReg=0 clamps to 2 rows.
    mreg = 7'd0;
    stream(4, 8'h21, 2, 0);

    // Drop wr_en with two words buffered: FLUSH drains them.
    full = 1'b1;
    res_val = 1'b1; res_data = 8'h31; tick();
    res_data = 8'h32; tick();
    res_val = 1'b0;
    chk("fl_rdy", 32'(res_rdy), 32'd0);
    chk("fl_wr0", 32'(wr_rq), 32'd0);
    chk("fl_idle0", 32'(idle), 32'd0);
    wr_en = 1'b0; full = 1'b0;
    tick();
    $display("flush1 wr_rq=%0b data=0x%0h idle=%0b", wr_rq, wr_data, idle);
    chk("fl_wr1", 32'(wr_rq), 32'd1);
    chk("fl_data1", 32'(wr_data), 32'h31);
    chk("fl_idle1", 32'(idle), 32'd0);
    tick();
    $display("flush2 wr_rq=%0b data=0x%0h idle=%0b", wr_rq, wr_data, idle);
    chk("fl_wr2", 32'(wr_rq), 32'd1);
    chk("fl_data2", 32'(wr_data), 32'h32);
    chk("fl_idle2", 32'(idle), 32'd1);
    tick();
    chk("fl_wr3", 32'(wr_rq), 32'd0);
    chk("fl_idle3", 32'(idle), 32'd1);
    chk("fl_cnt", 32'(stripe_cnt), 32'd3);

    // Overflow while buffered in IDLE.
    res_val = 1'b1; res_data = 8'h41; tick();
    res_data = 8'h42; tick();
    chk("ov_rdy", 32'(res_rdy), 32'd0);
    chk("ov_idle", 32'(idle), 32'd0);
    chk("ov_wr", 32'(wr_rq), 32'd0);
    res_data = 8'h43; tick();
    res_val = 1'b0;
    $display("overflow ovf=%0b rdy=%0b", ovf, res_rdy);
    chk("ov_set", 32'(ovf), 32'd1);
    tick();
    chk("ov_sticky", 32'(ovf), 32'd1);
    wr_en = 1'b1; tick();
    chk("ov_wr_idle", 32'(wr_rq), 32'd0);
    tick();
    chk("ov_wr1", 32'(wr_rq), 32'd1);
    chk("ov_data1", 32'(wr_data), 32'h41);
    tick();
    chk("ov_wr2", 32'(wr_rq), 32'd1);
    chk("ov_data2", 32'(wr_data), 32'h42);
    tick();
    chk("ov_no_drop_word", 32'(wr_rq), 32'd0);
    chk("ov_sticky2", 32'(ovf), 32'd1);
    eng_rstn = 1'b0; tick();
    chk("ov_clear", 32'(ovf), 32'd0);
    eng_rstn = 1'b1; tick();
    chk("ov_clear2", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/outbuff_cntl.md
Name: outbuff_cntl

Overview:
- Downstream neighbour of control_top; its datapath is fed by the engine.
- Accepts parity result words from the engine through a valid/ready handshake and holds them in a 2-entry skid buffer.
- Writes them into the output-buffer SRAM FIFO while control_top's cntrl_outbuff_wr_en is high and the FIFO is not full.
- Tracks parity-row and stripe position, and raises stripe-done, idle and overflow indications to control_top and the control registers.

Parameters:
- M_MAX, 128, maximum parity rows per stripe.
- M_MIN, 2, minimum parity rows per stripe.
- W, 4, Galois-field word width.
- PACKET_LENGTH, 2, words per packet.
- OUT_DATA_W, W*PACKET_LENGTH, result/FIFO data width (local, do not change).
- MREG_W, $clog2(M_MAX), MReg width (local).
- STRIPE_CNT_W, 16, stripe counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- eng_rstn  in  1  synchronous active-low soft reset from engine_fsm.
- cntrl_outbuff_wr_en  in  1  write enable from control_top.
- MReg  in  MREG_W  parity row count minus one.
- eng_res_data  in  OUT_DATA_W  engine result word.
- eng_res_val  in  1  result valid.
- eng_res_rdy  out  1  block can accept a result.
- cntl_outbuf_fifo_wr_rq  out  1  FIFO write request.
- cntl_outbuf_fifo_mem_en  out  1  FIFO memory enable.
- cntl_outbuf_fifo_wr_data  out  OUT_DATA_W  FIFO write data.
- outbuf_fifo_cntl_full  in  1  FIFO full.
- row_idx  out  MREG_W  parity row of the next word to be written.
- stripe_done  out  1  one-cycle pulse after the last row of a stripe is written.
- stripe_cnt  out  STRIPE_CNT_W  completed stripes, wraps.
- outbuf_cntl_idle  out  1  FSM in IDLE and buffer empty.
- ovf_err  out  1  sticky: a result was offered while eng_res_rdy was low.

Behaviour:
- Reset: rstn low asynchronously sets these outputs as follows.
  - All counters and buffer entries cleared; state IDLE.
  - eng_res_rdy=1, wr_rq=0, mem_en=0, wr_data=0, row_idx=0, stripe_done=0, stripe_cnt=0, outbuf_cntl_idle=1, ovf_err=0.
- Soft reset: eng_rstn low for one or more cycles gives the same values synchronously on the next edge. Buffered data is discarded, including mid-stripe.
- Row count: rows = MReg+1, clamped to a minimum of M_MIN. Example: MReg=0 gives 2 rows.
- Accept: a word is taken when eng_res_val && eng_res_rdy.
  - eng_res_rdy = (buffer count < 2); it is registered-derived with no combinational path from val.
  - An accept in the same cycle as a write is allowed at count 2 only if rdy was already high. It is not, so the engine must wait.
- Write condition: buffer non-empty && !outbuf_fifo_cntl_full && (state ACTIVE or FLUSH).
- Write timing: wr_rq, mem_en and wr_data are registered. A word accepted in cycle N into an empty buffer appears on wr_data with wr_rq=1 in cycle N+1 if the write condition held at N+1's decision edge. Minimum latency is 1 cycle.
- Throughput: one word per cycle when the FIFO is not full.
- Ordering: strict FIFO order; the oldest entry is written first. Simultaneous accept and write keeps the count unchanged.
- Full FIFO: wr_rq=0 while full; data is held and nothing is dropped.
- Row counter: increments on each write. On a write with row_idx==rows-1, row_idx wraps to 0, stripe_done pulses the next cycle and stripe_cnt increments (wrapping at 2^STRIPE_CNT_W).
- MReg changes are sampled only when row_idx==0.
- FSM states:
  - IDLE: go to ACTIVE when cntrl_outbuff_wr_en=1.
  - ACTIVE: when wr_en=0, go to FLUSH if the buffer is non-empty, else IDLE.
  - FLUSH: keep writing until the buffer is empty, then go to IDLE. If wr_en returns to 1, go back to ACTIVE.
- Words accepted in IDLE are buffered but not written.
- Overflow: eng_res_val=1 while eng_res_rdy=0 sets ovf_err. The word is dropped and the buffer is unchanged. ovf_err is cleared only by rstn or eng_rstn.

Test Plan:
- Reset then MReg=3, wr_en=1, 8 back-to-back results 0x01..0x08, FIFO never full.
  -> wr_rq 8 consecutive cycles, each 1 cycle after its accept.
  -> data 0x01..0x08 in order.
  -> stripe_done pulses after 0x04 and 0x08; stripe_cnt=2.
- FIFO full held 5 cycles during stream -> rdy drops after 2 buffered words; no wr_rq while full; no loss; order kept on release.
- MReg=0 -> rows clamp to 2; stripe_done after every second write.
- Drop wr_en with 2 words buffered -> FLUSH writes both, then IDLE; outbuf_cntl_idle=1.
- eng_res_val asserted while rdy=0 -> ovf_err=1 sticky; eng_rstn pulse clears it.
- eng_rstn low mid-stripe with row_idx=2 and 1 word buffered -> next cycle row_idx=0, buffer empty, rdy=1, no spurious wr_rq.
